// File: rtl/lane_striper_4l.sv
// -----------------------------------------------------------------------------
// lane_striper_4l
//   Byte-to-lane striper feeding the L2 lane stage. A serial byte stream is
//   distributed round-robin over lanes 0..3. Each complete 4-byte group is
//   published on Salida0..3 with per-lane valids. A partial group can be forced
//   out with flush, or by an optional idle timeout.
//
//   Optional feature macro: LANE_STRIPER_IDLE_FLUSH_EN
//     defined   -> a partial group is auto-emitted after IDLE_TIMEOUT idle
//                  cycles (validEntrada=0) while bytes are held.
//     undefined -> partial groups leave only on flush or further data.
//
// Ports
//   clk_4f          in   single rising-edge clock
//   reset           in   asynchronous, active-low
//   Entrada         in   input byte (WIDTH bits)
//   validEntrada    in   Entrada accepted this cycle (no backpressure)
//   flush           in   emit the partial group
//   Salida0..3      out  lane data of the last emitted group
//   validSalida0..3 out  lane N carries a valid byte of the last group
//   group_done      out  1-cycle pulse when the outputs update
//   lane_ptr        out  lane the next accepted byte goes to
//   grp_cnt         out  emitted-group counter, wraps 255->0
// -----------------------------------------------------------------------------
module lane_striper_4l #(
  parameter int WIDTH        = 8,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [WIDTH-1:0] Entrada,
  input  logic             validEntrada,
  input  logic             flush,
  output logic [WIDTH-1:0] Salida0,
  output logic [WIDTH-1:0] Salida1,
  output logic [WIDTH-1:0] Salida2,
  output logic [WIDTH-1:0] Salida3,
  output logic             validSalida0,
  output logic             validSalida1,
  output logic             validSalida2,
  output logic             validSalida3,
  output logic             group_done,
  output logic [1:0]       lane_ptr,
  output logic [7:0]       grp_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FILL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] hold_q [3];
  logic [WIDTH-1:0] sal_q  [4];
  logic [WIDTH-1:0] sal_d  [4];
  logic [3:0]       vld_q, vld_d;
  logic             done_q, done_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0] merged [4];
  logic [3:0]       lane_on;
  logic [2:0]       fill_cnt;
  logic             emit_full;
  logic             emit_part;
  logic             idle_fire;

  // Bytes held plus the one being accepted this cycle: this is what an
  // emission in this cycle must publish.
  assign fill_cnt  = {1'b0, ptr_q} + {2'b00, validEntrada};
  assign emit_full = validEntrada && (ptr_q == 2'd3);
  // A partial emission needs at least one byte (held or arriving); a full
  // group takes priority so flush on the 4th byte does not emit twice.
  assign emit_part = !emit_full && (flush || idle_fire) && (fill_cnt != 3'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < 3) begin : g_held
        // Bypass so a byte accepted in the emitting cycle is included.
        assign merged[gi] = (validEntrada && (ptr_q == 2'(gi))) ? Entrada : hold_q[gi];

        always_ff @(posedge clk_4f or negedge reset) begin
          if (!reset) begin
            hold_q[gi] <= '0;
          end else if (validEntrada && (ptr_q == 2'(gi))) begin
            hold_q[gi] <= Entrada;
          end
        end
      end else begin : g_direct
        // Lane 3 is only ever published by the accepting cycle itself, so the
        // byte goes straight to the output register with no holding stage.
        assign merged[gi] = Entrada;
      end
      assign lane_on[gi] = (3'(gi) < fill_cnt);
    end
  endgenerate

`ifdef LANE_STRIPER_IDLE_FLUSH_EN
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;

  // Fires on the IDLE_TIMEOUT-th consecutive idle cycle in FILL.
  assign idle_fire = (state_q == FILL) && !validEntrada &&
                     (idle_q == IW'(IDLE_TIMEOUT - 1));

  always_comb begin
    idle_d = idle_q;
    if (validEntrada || (state_d == EMPTY)) begin
      idle_d = '0;
    end else if (state_q == FILL) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_idle_timeout;
  assign unused_idle_timeout = (IDLE_TIMEOUT == 0);
  assign idle_fire           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    for (int i = 0; i < 4; i++) begin
      sal_d[i] = sal_q[i];
    end

    if (validEntrada) begin
      ptr_d = ptr_q + 2'd1;
    end

    if (emit_full || emit_part) begin
      ptr_d   = 2'd0;
      state_d = EMPTY;
      done_d  = 1'b1;
      cnt_d   = cnt_q + 8'd1;
      vld_d   = lane_on;
      for (int i = 0; i < 4; i++) begin
        sal_d[i] = lane_on[i] ? merged[i] : '0;
      end
    end else if (validEntrada) begin
      state_d = FILL;
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      ptr_q   <= 2'd0;
      vld_q   <= 4'd0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        sal_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 4; i++) begin
        sal_q[i] <= sal_d[i];
      end
    end
  end

  assign Salida0      = sal_q[0];
  assign Salida1      = sal_q[1];
  assign Salida2      = sal_q[2];
  assign Salida3      = sal_q[3];
  assign validSalida0 = vld_q[0];
  assign validSalida1 = vld_q[1];
  assign validSalida2 = vld_q[2];
  assign validSalida3 = vld_q[3];
  assign group_done   = done_q;
  assign lane_ptr     = ptr_q;
  assign grp_cnt      = cnt_q;

endmodule
